code_unshifter: RTL and testbench
=================================

# code_unshifter

Variable-length code extractor for the entropy-decode path: the receive-side counterpart of `code_shifter`. It accepts fixed-width, MSB-first packed words and presents an MSB-aligned bit window from which the downstream decoder consumes 1..WIDTH bits per cycle. A 2×WIDTH-bit buffer lets one input word load in the same cycle as a consume. `flush` discards leftover padding at the end of a segment.

## Interface
- `WIDTH`, 16, packed word width and maximum code size.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state.
- `ena_in`  in  1  `in` holds a valid packed word.
- `in`  in  WIDTH  packed word; bit WIDTH-1 is the first bit in the stream.
- `rdy_out`  out  1  block can accept a word this cycle.
- `take`  in  1  consumer removes `size` bits from the head of the window.
- `size`  in  $clog2(WIDTH)+1  bits to remove, legal range 1..WIDTH.
- `flush`  in  1  discard all buffered bits.
- `window`  out  WIDTH  next WIDTH stream bits, MSB-aligned. A code of length s is `window[WIDTH-1 -: s]`. Bits at and beyond `count` read 0.
- `count`  out  $clog2(2*WIDTH+1)  number of valid buffered bits, 0..2×WIDTH.
- `err`  out  1  sticky flag for an illegal take; cleared only by reset.

## Operation
- **State:** `buf[2*WIDTH-1:0]` (MSB = head of stream), `cnt`, `err`.
- **Outputs:**
  - `window = buf[2*WIDTH-1 -: WIDTH]`.
  - `count = cnt`.
  - `rdy_out = (cnt <= WIDTH)`, computed combinationally from registered `cnt` only; it does not depend on `take`.
- **Legal take:** `take && size >= 1 && size <= WIDTH && size <= cnt`.
  - `buf` shifts left by `size`, filling with 0.
  - `cnt` decreases by `size`.
- **Illegal take:** `take` with `size == 0`, `size > WIDTH` or `size > cnt`.
  - `buf` and `cnt` are unchanged.
  - `err` sets to 1.
  - A word load in the same cycle still happens.
- **Load:** `ena_in && rdy_out`.
  - `in` is written at bit offsets [2*WIDTH-1-c' -: WIDTH], where c' is `cnt` after any same-cycle legal take.
  - `cnt` becomes c'+WIDTH.
  - If `ena_in` is asserted while `rdy_out` is low, the word is ignored. The upstream holds it.
- **Take and load in the same cycle:** the take is applied first, then the load is appended after the surviving bits. The result never exceeds 2×WIDTH.
- **Flush:** has priority over take and load.
  - `buf` becomes 0, `cnt` becomes 0.
  - A word or take presented in the flush cycle is dropped.
  - `err` is unaffected.
- **Invariant:** buffer bits below position 2*WIDTH-1-cnt are always 0.

## Timing
- **Reset values:** `buf=0`, `cnt=0`, `err=0`. So `window=0`, `count=0`, `rdy_out=1`. Reset takes effect asynchronously; outputs are valid the cycle after reset is released.
- **Mid-operation reset:** all buffered bits are lost immediately, with no partial-word retention.
- **Latency:** a word accepted at edge N is visible in `window`/`count` after edge N. A take at edge N is reflected after edge N.
- **Full (cnt=2×WIDTH):** `rdy_out=0`. A take of s bits at edge N makes `rdy_out=1` after edge N if s ≥ WIDTH... more precisely, whenever the new cnt ≤ WIDTH.
- **Empty (cnt=0):** `window=0`. Any take is illegal. A load makes cnt=WIDTH.
- **Throughput:** sustains one word per cycle when the consumer takes WIDTH bits per cycle. Example: cnt=WIDTH, take WIDTH plus load gives cnt=WIDTH again.
- **Combinational paths:** none from `take`/`size`/`flush` to any output. All outputs are registered or derived only from registers.

## Test plan
- **Reset:** pulse `rst` low mid-cycle with cnt=20 -> immediately `count=0`, `window=0`, `rdy_out=1`, `err=0`.
- **Decode stream (WIDTH=16):**
  - Stimulus: load 1000000000110000, 0110101010101010 and 1100000000000000, then take sizes 11, 7, 16.
  - Required: windows before each take hold head 10000000001, 1000001 and 1010101010101011 respectively.
  - Final state: `count=14`, `window=0`. Then `flush` gives `count=0`.
- **Take plus load:** cnt=16, take 16 plus load 0xA5A5 in one cycle -> `window=0xA5A5`, `count=16`.
- **Full/backpressure:** with cnt=32, hold `ena_in=1` with 0x1234 -> `rdy_out=0`, word not absorbed. Take 16 -> `rdy_out=1`, next edge loads 0x1234 behind the remaining 16 bits, `count=32`.
- **Illegal takes:** take 5 at cnt=3; take 0; take 17 -> `buf`/`count` unchanged and `err=1`. `err` stays set after `flush` and clears only on `rst`.
- **Flush priority:** `flush` with simultaneous `ena_in` and `take` at cnt=9 -> `count=0`, `window=0`, word dropped.

Source files
------------

// File: rtl/code_unshifter.sv
// code_unshifter: receive-side variable-length code extractor.
// Packed MSB-first words are appended behind the surviving bits of a
// 2*WIDTH buffer. The decoder reads an MSB-aligned WIDTH-bit window and
// removes 1..WIDTH bits per cycle. Every output comes straight from registers.
module code_unshifter #(
    parameter int WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena_in,
    input  logic [WIDTH-1:0]               in,
    output logic                           rdy_out,
    input  logic                           take,
    input  logic [$clog2(WIDTH):0]         size,
    input  logic                           flush,
    output logic [WIDTH-1:0]               window,
    output logic [$clog2(2*WIDTH+1)-1:0]   count,
    output logic                           err
);

    localparam int NW = $clog2(2*WIDTH+1);
    localparam logic [NW-1:0] W_N = NW'(WIDTH);

    logic [2*WIDTH-1:0] buf_q, buf_t, buf_n;
    logic [NW-1:0]      cnt_q, cnt_t, cnt_n;
    logic               err_q, err_n;
    logic [NW-1:0]      size_x;
    logic               legal, load;

    assign size_x  = NW'(size);
    assign window  = buf_q[2*WIDTH-1 -: WIDTH];
    assign count   = cnt_q;
    assign err     = err_q;
    // Readiness depends only on registered occupancy, so it is never
    // combinationally tied to the same-cycle take.
    assign rdy_out = (cnt_q <= W_N);

    // Next state: apply a legal take, then append any accepted word behind
    // the surviving bits. Flush overrides both but leaves err alone.
    always_comb begin
        legal = take && (size_x != '0) && (size_x <= W_N) && (size_x <= cnt_q);
        load  = ena_in && rdy_out;
        buf_t = legal ? (buf_q << size) : buf_q;
        cnt_t = legal ? (cnt_q - size_x) : cnt_q;
        // Bits below the surviving ones are zero, so OR places the new word.
        buf_n = load ? (buf_t | ({in, {WIDTH{1'b0}}} >> cnt_t)) : buf_t;
        cnt_n = load ? (cnt_t + W_N) : cnt_t;
        err_n = err_q | (take && !legal);
        if (flush) begin
            buf_n = '0;
            cnt_n = '0;
            err_n = err_q;
        end
    end

    // State registers; reset drops all buffered bits at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            buf_q <= buf_n;
            cnt_q <= cnt_n;
            err_q <= err_n;
        end
    end

endmodule

// File: tb/tb_code_unshifter.sv
// Directed bench for code_unshifter. A bit-queue stream model produces the
// expected window/count/rdy/err; each step pushes its expectation into a
// scoreboard that is popped once the DUT has taken the clock edge.
module tb_code_unshifter;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena_in, take, flush;
    logic [W-1:0]  in_w;
    logic [4:0]    size;
    logic          rdy_out, err;
    logic [W-1:0]  window;
    logic [5:0]    count;

    typedef struct {
        logic [W-1:0] win;
        logic [5:0]   cnt;
        logic         rdy;
        logic         err;
    } exp_t;

    exp_t sb[$];
    bit   mq[$];
    bit   merr;
    int   n_assert = 0;
    int   n_fail   = 0;

    code_unshifter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ena_in(ena_in), .in(in_w), .rdy_out(rdy_out),
        .take(take), .size(size), .flush(flush), .window(window),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from the stream model: head bits of the queue, 0-padded.
    function automatic exp_t model_exp();
        exp_t e;
        e.win = '0;
        for (int i = 0; i < W; i++)
            if (i < mq.size()) e.win[W-1-i] = mq[i];
        e.cnt = 6'(mq.size());
        e.rdy = (mq.size() <= W);
        e.err = merr;
        return e;
    endfunction

    task automatic model_apply(input logic e, input logic [W-1:0] w, input logic t,
                               input logic [4:0] s, input logic f);
        bit rdy_pre;
        rdy_pre = (mq.size() <= W);
        if (f) begin
            mq.delete();
        end else begin
            if (t) begin
                if (s >= 1 && s <= W && int'(s) <= mq.size())
                    for (int i = 0; i < int'(s); i++) void'(mq.pop_front());
                else
                    merr = 1'b1;
            end
            if (e && rdy_pre)
                for (int i = W-1; i >= 0; i--) mq.push_back(w[i]);
        end
    endtask

    task automatic compare_sb(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, ".window"}, 32'(window), 32'(e.win));
        check({tag, ".count"},  32'(count),  32'(e.cnt));
        check({tag, ".rdy"},    32'(rdy_out), 32'(e.rdy));
        check({tag, ".err"},    32'(err),    32'(e.err));
    endtask

    task automatic step(input string tag, input logic e, input logic [W-1:0] w,
                        input logic t, input logic [4:0] s, input logic f);
        ena_in = e; in_w = w; take = t; size = s; flush = f;
        model_apply(e, w, t, s, f);
        sb.push_back(model_exp());
        @(posedge clk);
        #1;
        ena_in = 1'b0; take = 1'b0; flush = 1'b0; size = '0;
        compare_sb(tag);
    endtask

    initial begin
        rst = 1'b0; ena_in = 1'b0; take = 1'b0; flush = 1'b0; size = '0; in_w = '0;
        merr = 1'b0;
        #12 rst = 1'b1;
        @(posedge clk); #1;
        sb.push_back(model_exp());
        compare_sb("reset");

        // Decode stream: third word waits for room while takes drain the buffer.
        step("ldA", 1, 16'h8030, 0, 0, 0);
        step("ldB", 1, 16'h6AAA, 0, 0, 0);
        check("head11", 32'(window[15 -: 11]), 32'(11'b10000000001));
        step("tk11", 1, 16'hC000, 1, 11, 0);
        check("head7", 32'(window[15 -: 7]), 32'(7'b1000001));
        step("tk7", 1, 16'hC000, 1, 7, 0);
        step("ldC", 1, 16'hC000, 0, 0, 0);
        check("head16", 32'(window), 32'(16'b1010101010101011));
        step("tk16", 0, 16'h0, 1, 16, 0);
        check("final_cnt", 32'(count), 32'd14);
        check("final_win", 32'(window), 32'd0);
        step("flush1", 0, 16'h0, 0, 0, 1);
        check("flush_cnt", 32'(count), 32'd0);

        // Take WIDTH plus load in the same cycle.
        step("ldX", 1, 16'h5555, 0, 0, 0);
        step("tkld", 1, 16'hA5A5, 1, 16, 0);
        check("tkld_win", 32'(window), 32'hA5A5);
        check("tkld_cnt", 32'(count), 32'd16);

        // Full buffer holds off the upstream word until a take frees room.
        step("ldF", 1, 16'hFFFF, 0, 0, 0);
        step("hold", 1, 16'h1234, 0, 0, 0);
        check("hold_cnt", 32'(count), 32'd32);
        step("free", 1, 16'h1234, 1, 16, 0);
        check("free_rdy", 32'(rdy_out), 32'd1);
        step("ld1234", 1, 16'h1234, 0, 0, 0);
        check("bp_cnt", 32'(count), 32'd32);
        step("tkF", 0, 16'h0, 1, 16, 0);
        check("bp_win", 32'(window), 32'h1234);

        // Flush beats a simultaneous load and take.
        step("flush2", 0, 16'h0, 0, 0, 1);
        step("ld9", 1, 16'h7F80, 0, 0, 0);
        step("tk7b", 0, 16'h0, 1, 7, 0);
        check("pre_cnt9", 32'(count), 32'd9);
        step("flushpri", 1, 16'hBEEF, 1, 3, 1);
        check("fp_cnt", 32'(count), 32'd0);
        check("fp_win", 32'(window), 32'd0);

        // Illegal takes leave state alone and set the sticky error.
        step("ld3", 1, 16'h0007, 0, 0, 0);
        step("tk13", 0, 16'h0, 1, 13, 0);
        step("ill5", 0, 16'h0, 1, 5, 0);
        check("ill5_win", 32'(window), 32'hE000);
        check("ill5_err", 32'(err), 32'd1);
        step("ill0", 0, 16'h0, 1, 0, 0);
        step("ill17", 0, 16'h0, 1, 17, 0);
        step("flush3", 0, 16'h0, 0, 0, 1);
        check("err_sticky", 32'(err), 32'd1);

        // Asynchronous reset mid-cycle with 20 bits buffered.
        step("ldR1", 1, 16'hBEEF, 0, 0, 0);
        step("ldR2", 1, 16'h1357, 0, 0, 0);
        step("tk12", 0, 16'h0, 1, 12, 0);
        check("pre_rst_cnt", 32'(count), 32'd20);
        #2 rst = 1'b0;
        #1;
        mq.delete();
        merr = 1'b0;
        sb.push_back(model_exp());
        compare_sb("async_rst");
        #1 rst = 1'b1;
        step("post_rst", 1, 16'h00FF, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
